unidade_controle_multiciclo: RTL

- Multicycle control unit for the 64-bit RISC-V datapath.
- Sits directly downstream of the instruction register. Consumes opcode, funct3 and funct7[5] from the IR, plus the ULA zero flag.
- Drives every load enable, mux select and write strobe: PC, IR, A/B registers, ALUOut, MDR, register bank, data memory.
- Supported instructions: add, sub, and, addi, ld, sd, beq, bne, lui. Any other encoding traps.

---
 rtl/unidade_controle_multiciclo.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit for the 64-bit RISC-V datapath: one FSM sequences
// fetch, decode, execute, memory and write-back for a small integer subset.
module unidade_controle_multiciclo #(
  parameter int unsigned IMEM_WAIT = 1,
  parameter int unsigned DMEM_WAIT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] INSTR6_0,
  input  logic [2:0] FUNCT3,
  input  logic       FUNCT7_5,
  input  logic       ZERO,
  output logic       RESET_WIRE,
  output logic       WRITE_PC,
  output logic       PC_SRC,
  output logic       LOAD_IR,
  output logic       LOAD_AB,
  output logic       LOAD_ALUOUT,
  output logic       LOAD_MDR,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] ULA_OP,
  output logic       REG_WRITE,
  output logic [1:0] MEM_TO_REG,
  output logic       DMEM_WR,
  output logic       ILLEGAL,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,  S_IF_WAIT = 4'd1,  S_IF      = 4'd2,  S_DECODE  = 4'd3,
    S_EX_R    = 4'd4,  S_EX_I    = 4'd5,  S_MEM_RD  = 4'd6,  S_MEM_RD2 = 4'd7,
    S_WB_ALU  = 4'd8,  S_WB_MEM  = 4'd9,  S_WB_LUI  = 4'd10, S_MEM_WR  = 4'd11,
    S_BRANCH  = 4'd12, S_PC_INC  = 4'd13, S_TRAP    = 4'd14
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ULA_ADD = 3'b001;
  localparam logic [2:0] ULA_SUB = 3'b010;
  localparam logic [2:0] ULA_AND = 3'b011;

  localparam logic [3:0] IMEM_LOAD = 4'(IMEM_WAIT - 1);
  localparam logic [3:0] DMEM_LOAD = 4'(DMEM_WAIT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic       w_cnt_done;
  logic       w_taken;

  assign w_cnt_done = (r_wait_cnt == 4'd0);
  assign w_taken    = (FUNCT3 == 3'b000) ? ZERO : !ZERO;
  assign STATE      = r_state;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_RESET;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_next == S_IF_WAIT && r_state != S_IF_WAIT)
        r_wait_cnt <= IMEM_LOAD;
      else if (w_next == S_MEM_RD && r_state != S_MEM_RD)
        r_wait_cnt <= DMEM_LOAD;
      else if (!w_cnt_done)
        r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // NOTE: every output and w_next gets a default first, so no path infers a latch.
  always_comb begin
    w_next      = r_state;
    RESET_WIRE  = 1'b0;
    WRITE_PC    = 1'b0;
    PC_SRC      = 1'b0;
    LOAD_IR     = 1'b0;
    LOAD_AB     = 1'b0;
    LOAD_ALUOUT = 1'b0;
    LOAD_MDR    = 1'b0;
    ALU_SRC_A   = 1'b0;
    ALU_SRC_B   = 2'b00;
    ULA_OP      = 3'b000;
    REG_WRITE   = 1'b0;
    MEM_TO_REG  = 2'b00;
    DMEM_WR     = 1'b0;
    ILLEGAL     = 1'b0;

    case (r_state)
      S_RESET: begin
        RESET_WIRE = 1'b1;
        w_next     = S_IF_WAIT;
      end
      S_IF_WAIT: if (w_cnt_done) w_next = S_IF;
      S_IF: begin
        LOAD_IR = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures the branch target PC + (imm << 1) while decoding.
        LOAD_AB     = 1'b1;
        ALU_SRC_B   = 2'b11;
        ULA_OP      = ULA_ADD;
        LOAD_ALUOUT = 1'b1;
        case (INSTR6_0)
          OP_R:         w_next = (FUNCT3 == 3'b000 || (FUNCT3 == 3'b111 && !FUNCT7_5))
                                 ? S_EX_R : S_TRAP;
          OP_I:         w_next = (FUNCT3 == 3'b000) ? S_EX_I : S_TRAP;
          OP_LD, OP_SD: w_next = (FUNCT3 == 3'b011) ? S_EX_I : S_TRAP;
          OP_BR:        w_next = (FUNCT3 == 3'b000 || FUNCT3 == 3'b001) ? S_BRANCH : S_TRAP;
          OP_LUI:       w_next = S_WB_LUI;
          default:      w_next = S_TRAP;
        endcase
      end
      S_EX_R: begin
        ALU_SRC_A   = 1'b1;
        ULA_OP      = (FUNCT3 == 3'b111) ? ULA_AND : (FUNCT7_5 ? ULA_SUB : ULA_ADD);
        LOAD_ALUOUT = 1'b1;
        w_next      = S_WB_ALU;
      end
      S_EX_I: begin
        ALU_SRC_A   = 1'b1;
        ALU_SRC_B   = 2'b10;
        ULA_OP      = ULA_ADD;
        LOAD_ALUOUT = 1'b1;
        if (INSTR6_0 == OP_LD)      w_next = S_MEM_RD;
        else if (INSTR6_0 == OP_SD) w_next = S_MEM_WR;
        else                        w_next = S_WB_ALU;
      end
      S_MEM_RD: if (w_cnt_done) w_next = S_MEM_RD2;
      S_MEM_RD2: begin
        LOAD_MDR = 1'b1;
        w_next   = S_WB_MEM;
      end
      S_WB_ALU: begin
        REG_WRITE = 1'b1;
        w_next    = S_PC_INC;
      end
      S_WB_MEM: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 2'b01;
        w_next     = S_PC_INC;
      end
      S_WB_LUI: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 2'b10;
        w_next     = S_PC_INC;
      end
      S_MEM_WR: begin
        DMEM_WR = 1'b1;
        w_next  = S_PC_INC;
      end
      S_BRANCH: begin
        ALU_SRC_A = 1'b1;
        ULA_OP    = ULA_SUB;
        if (w_taken) begin
          WRITE_PC = 1'b1;
          PC_SRC   = 1'b1;
          w_next   = S_IF_WAIT;
        end else begin
          w_next   = S_PC_INC;
        end
      end
      S_PC_INC: begin
        ALU_SRC_B = 2'b01;
        ULA_OP    = ULA_ADD;
        WRITE_PC  = 1'b1;
        w_next    = S_IF_WAIT;
      end
      S_TRAP: ILLEGAL = 1'b1;
      default: w_next = S_TRAP;
    endcase
  end

endmodule
